// File: rtl/dvi_tx_clk_gen.sv
// dvi_tx_clk_gen: DDR forwarded-clock pattern generator with divide ratio, polarity invert and glitch-free start/stop.
// Optional period counter output enabled by defining DVI_TX_CLK_CNT_EN.
module dvi_tx_clk_gen #(
    parameter int N_CH  = 2,
    parameter int DIV_W = 4
) (
    input  logic             pixel_clock,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [N_CH-1:0]  inv,
    output logic             en_ack,
    output logic             running,
    output logic             tick,
`ifdef DVI_TX_CLK_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic [N_CH-1:0]  d1,
    output logic [N_CH-1:0]  d2
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [DIV_W:0] ph, ph_inc, ph_nx, s2, two_h, h_ext;
    logic [DIV_W-1:0] div_q;
    logic p1, p2, last, start;
    assign two_h  = {div_q, 1'b0};
    assign h_ext  = {1'b0, div_q};
    assign ph_inc = ph + (DIV_W+1)'(2);
    assign last   = ph_inc >= two_h;
    assign ph_nx  = last ? ph_inc - two_h : ph_inc;
    assign s2     = (ph + (DIV_W+1)'(1) == two_h) ? '0 : ph + (DIV_W+1)'(1);
    assign start  = state == IDLE && en_req;
    always_ff @(posedge pixel_clock) begin
        if (!rst_n) begin
            state <= IDLE;
            ph    <= '0;
            div_q <= DIV_W'(1);
            p1    <= 1'b0;
            p2    <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                p1   <= 1'b0;
                p2   <= 1'b0;
                tick <= 1'b0;
                if (en_req) begin
                    div_q <= (div_sel == '0) ? DIV_W'(1) : div_sel;
                    ph    <= '0;
                end
            end else begin
                p1   <= ph < h_ext;
                p2   <= s2 < h_ext;
                tick <= ph == '0;
                ph   <= ph_nx;
            end
        end
    end
    // DRAIN only retires on the last pair of a period so the final slot is always low
    always_comb begin
        state_nx = (state == IDLE) ? (en_req ? RUN : IDLE) :
                   (state == RUN)  ? (en_req ? RUN : DRAIN) :
                                     (en_req ? RUN : (last ? IDLE : DRAIN));
    end
    always_comb begin
        en_ack  = state == RUN;
        running = state != IDLE;
        d1      = {N_CH{p1}} ^ inv;
        d2      = {N_CH{p2}} ^ inv;
    end
`ifdef DVI_TX_CLK_CNT_EN
    always_ff @(posedge pixel_clock) begin
        if (!rst_n || start)
            period_cnt <= '0;
        else if (state != IDLE && ph == '0 && period_cnt != 16'hFFFF)
            period_cnt <= period_cnt + 16'd1;
    end
`endif
endmodule
